// File: rtl/mac_stream_dot_if.sv
`default_nettype none
// ============================================================================
// Module   : mac_stream_dot_if
// Brief    : Coefficient-write port plus sample/result valid-ready streams.
// Revision : 1.0 - initial release
// ============================================================================
interface mac_stream_dot_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) ();
    logic              coef_we;
    logic [ADDR_W-1:0] coef_addr;
    logic [DATA_W-1:0] coef_wdata;
    logic              accumulate;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_sat;

    modport master (
        output coef_we, coef_addr, coef_wdata, accumulate,
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  coef_we, coef_addr, coef_wdata, accumulate,
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface
`default_nettype wire

// File: rtl/mac_stream_dot.sv
`default_nettype none
// ============================================================================
// Module   : mac_stream_dot
// Brief    : Streaming fixed-point dot product with saturated output.
// Revision : 1.0 - initial release
// ============================================================================
module mac_stream_dot #(
    parameter int DATA_W = 32,
    parameter int FRAC_W = 16,
    parameter int N_TAPS = 16,
    parameter int ADDR_W = $clog2(N_TAPS)
) (
    input  wire             clk,
    input  wire             reset,
    mac_stream_dot_if.slave bus
);
    localparam int ACC_W  = 2*DATA_W - FRAC_W + $clog2(N_TAPS) + 1;
    localparam int PROD_W = 2*DATA_W;

    localparam logic [DATA_W-1:0] c_coef_one = DATA_W'(1) << FRAC_W;
    localparam logic [ADDR_W-1:0] c_last_tap = ADDR_W'(N_TAPS - 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_flush = 2'd2;
    localparam logic [1:0] c_st_hold  = 2'd3;

    logic [1:0]               r_state;
    logic [1:0]               w_state_nxt;
    logic [ADDR_W-1:0]        r_tap;
    logic                     r_flush_cnt;
    logic [DATA_W-1:0]        r_coef [N_TAPS];

    logic signed [DATA_W-1:0] w_sample;
    logic signed [DATA_W-1:0] w_coef;
    logic signed [PROD_W-1:0] r_prod;
    logic                     r_s1_valid;
    logic                     r_s1_first;
    logic                     r_s1_seed;
    logic [ACC_W-1:0]         w_prod_acc;
    logic [ACC_W-1:0]         r_acc;

    logic [ACC_W-DATA_W:0]    w_acc_hi;
    logic                     w_fits;
    logic [DATA_W-1:0]        w_sat_val;

    logic                     w_accept;
    logic                     w_in_ready_nxt;
    logic                     w_out_valid_nxt;
    logic                     w_load_out;
    logic                     r_in_ready;
    logic                     r_out_valid;
    logic [DATA_W-1:0]        r_out_data;
    logic                     r_out_sat;

    assign w_accept = bus.in_valid & r_in_ready;
    assign w_sample = bus.in_data;
    assign w_coef   = r_coef[r_tap];

    // Write-first ordering is avoided on purpose: a sample accepted in the
    // write cycle multiplies the register value from before the write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_TAPS; i++) r_coef[i] <= c_coef_one;
        end else begin
            for (int i = 0; i < N_TAPS; i++) begin
                if (bus.coef_we && (bus.coef_addr == ADDR_W'(i)))
                    r_coef[i] <= bus.coef_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= c_st_idle;
            r_tap       <= '0;
            r_flush_cnt <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept)
                r_tap <= (r_tap == c_last_tap) ? '0 : r_tap + 1'b1;
            r_flush_cnt <= (r_state == c_st_flush) ? ~r_flush_cnt : 1'b0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (w_accept) w_state_nxt = c_st_run;
            c_st_run:   if (w_accept && (r_tap == c_last_tap)) w_state_nxt = c_st_flush;
            c_st_flush: if (r_flush_cnt) w_state_nxt = c_st_hold;
            c_st_hold:  if (bus.out_ready) w_state_nxt = c_st_idle;
            default:    w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        w_in_ready_nxt  = (w_state_nxt == c_st_idle) || (w_state_nxt == c_st_run);
        w_out_valid_nxt = (w_state_nxt == c_st_hold);
        w_load_out      = (r_state == c_st_flush) && (w_state_nxt == c_st_hold);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prod     <= '0;
            r_s1_valid <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_seed  <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_prod     <= PROD_W'(w_sample) * PROD_W'(w_coef);
                r_s1_first <= (r_tap == '0);
                r_s1_seed  <= bus.accumulate;
            end
        end
    end

    // Arithmetic shift floors toward minus infinity before widening.
    assign w_prod_acc = ACC_W'(r_prod >>> FRAC_W);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc <= '0;
        end else if (r_s1_valid) begin
            r_acc <= ((r_s1_first && !r_s1_seed) ? '0 : r_acc) + w_prod_acc;
        end
    end

    // The sum fits in DATA_W bits when every bit from DATA_W-1 upward matches.
    assign w_acc_hi  = r_acc[ACC_W-1:DATA_W-1];
    assign w_fits    = (&w_acc_hi) | ~(|w_acc_hi);
    assign w_sat_val = r_acc[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                      : {1'b0, {(DATA_W-1){1'b1}}};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
        end else begin
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            if (w_load_out) begin
                r_out_data <= w_fits ? r_acc[DATA_W-1:0] : w_sat_val;
                r_out_sat  <= ~w_fits;
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_sat   = r_out_sat;

endmodule
`default_nettype wire

// File: tb/tb_mac_stream_dot.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_stream_dot
// Brief    : Directed vector bench for the streaming dot-product engine.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_stream_dot;
    localparam int DATA_W = 32;
    localparam int FRAC_W = 16;
    localparam int N_TAPS = 16;
    localparam int ADDR_W = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mac_stream_dot_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    mac_stream_dot #(
        .DATA_W(DATA_W),
        .FRAC_W(FRAC_W),
        .N_TAPS(N_TAPS),
        .ADDR_W(ADDR_W)
    ) u_dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        int          kind;      // 0: ramp i<<16, 1: every sample = val
        logic [31:0] val;
        bit          acc;
        bit          gaps;
        logic [31:0] exp_data;
        bit          exp_sat;
    } vec_t;

    vec_t        tbl [11];
    logic [31:0] vec [N_TAPS];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          hook_tap = -1;
    logic [3:0]  hook_addr = '0;
    logic [31:0] hook_val = '0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic write_coef(input logic [3:0] addr, input logic [31:0] val);
        bus.coef_we    = 1'b1;
        bus.coef_addr  = addr;
        bus.coef_wdata = val;
        step();
        bus.coef_we    = 1'b0;
    endtask

    task automatic load_vec(input int kind, input logic [31:0] val);
        for (int i = 0; i < N_TAPS; i++)
            vec[i] = (kind == 0) ? (32'(i) << 16) : val;
    endtask

    // Streams vec[] in, then waits for out_valid; leaves the bench in the
    // first cycle where out_valid is seen (no handshake performed here).
    task automatic run_vector(input string tag, input bit acc, input bit gaps,
                              output logic [31:0] d, output logic s);
        int waited;
        int lat;
        d = '0;
        s = 1'b0;
        for (int t = 0; t < N_TAPS; t++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    bus.in_valid = 1'b0;
                    bus.in_data  = $urandom;
                    step();
                end
            end
            bus.in_valid   = 1'b1;
            bus.in_data    = vec[t];
            bus.accumulate = acc;
            if (t == hook_tap) begin
                bus.coef_we    = 1'b1;
                bus.coef_addr  = hook_addr;
                bus.coef_wdata = hook_val;
            end
            waited = 0;
            while (!bus.in_ready && waited < 50) begin
                step();
                waited++;
            end
            if (!bus.in_ready) begin
                check($sformatf("%s in_ready wait", tag), 32'(bus.in_ready), 32'd1);
                bus.in_valid = 1'b0;
                bus.coef_we  = 1'b0;
                return;
            end
            step();
            bus.coef_we = 1'b0;
        end
        bus.in_valid = 1'b0;
        bus.in_data  = 32'hDEAD_BEEF;
        lat = 1;
        while (!bus.out_valid && lat < 12) begin
            step();
            lat++;
        end
        check($sformatf("%s latency", tag), 32'(lat), 32'd3);
        d = bus.out_data;
        s = bus.out_sat;
    endtask

    task automatic run_and_check(input string tag, input bit acc, input bit gaps,
                                 input logic [31:0] exp_d, input bit exp_s);
        logic [31:0] d;
        logic        s;
        run_vector(tag, acc, gaps, d, s);
        check($sformatf("%s data", tag), d, exp_d);
        check($sformatf("%s sat", tag), 32'(s), 32'(exp_s));
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d;
        logic        s;

        bus.coef_we    = 1'b0;
        bus.coef_addr  = '0;
        bus.coef_wdata = '0;
        bus.accumulate = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.out_ready  = 1'b1;

        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        step();
        check("reset in_ready",  32'(bus.in_ready),  32'd1);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset out_data",  bus.out_data,       32'd0);
        check("reset out_sat",   32'(bus.out_sat),   32'd0);

        tbl[0]  = '{0, 32'h0000_0000, 1'b0, 1'b0, 32'h0078_0000, 1'b0};
        tbl[1]  = '{1, 32'h7FFF_0000, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b1};
        tbl[2]  = '{1, 32'h8000_0000, 1'b0, 1'b0, 32'h8000_0000, 1'b1};
        tbl[3]  = '{1, 32'h0001_0000, 1'b0, 1'b0, 32'h0010_0000, 1'b0};
        tbl[4]  = '{1, 32'h0001_0000, 1'b1, 1'b0, 32'h0020_0000, 1'b0};
        tbl[5]  = '{1, 32'h0001_0000, 1'b0, 1'b0, 32'h0010_0000, 1'b0};
        tbl[6]  = '{0, 32'h0000_0000, 1'b0, 1'b1, 32'h0078_0000, 1'b0};
        tbl[7]  = '{1, 32'hFFFF_0000, 1'b0, 1'b0, 32'hFFF0_0000, 1'b0};
        tbl[8]  = '{1, 32'h07FF_FFFF, 1'b0, 1'b0, 32'h7FFF_FFF0, 1'b0};
        tbl[9]  = '{1, 32'h0800_0000, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b1};
        tbl[10] = '{1, 32'hF800_0000, 1'b0, 1'b1, 32'h8000_0000, 1'b0};

        for (int i = 0; i < 11; i++) begin
            load_vec(tbl[i].kind, tbl[i].val);
            run_and_check($sformatf("tbl%0d", i), tbl[i].acc, tbl[i].gaps,
                          tbl[i].exp_data, tbl[i].exp_sat);
        end

        // Result must stay frozen while downstream stalls.
        bus.out_ready = 1'b0;
        load_vec(0, '0);
        run_vector("hold", 1'b0, 1'b0, d, s);
        check("hold first data", d, 32'h0078_0000);
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = $urandom;
            step();
            check($sformatf("hold%0d out_valid", k), 32'(bus.out_valid), 32'd1);
            check($sformatf("hold%0d out_data", k),  bus.out_data,       32'h0078_0000);
            check($sformatf("hold%0d out_sat", k),   32'(bus.out_sat),   32'd0);
            check($sformatf("hold%0d in_ready", k),  32'(bus.in_ready),  32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        check("release out_valid", 32'(bus.out_valid), 32'd0);
        check("release in_ready",  32'(bus.in_ready),  32'd1);
        load_vec(0, '0);
        run_and_check("after_hold", 1'b0, 1'b0, 32'h0078_0000, 1'b0);

        for (int i = 0; i < N_TAPS; i++) write_coef(4'(i), 32'h0);
        write_coef(4'd3, 32'h0002_0000);
        load_vec(1, 32'h0001_0000);
        vec[3] = 32'hFFFE_8000;
        run_and_check("coef_sparse", 1'b0, 1'b0, 32'hFFFD_0000, 1'b0);

        // Same-cycle write to the address in use: sample sees the old 2.0.
        load_vec(1, 32'h0001_0000);
        hook_tap = 3; hook_addr = 4'd3; hook_val = 32'h0001_0000;
        run_and_check("wr_same_cycle", 1'b0, 1'b0, 32'h0002_0000, 1'b0);
        // Write during tap 3 is visible to tap 4 one cycle later.
        hook_tap = 3; hook_addr = 4'd4; hook_val = 32'h0003_0000;
        run_and_check("wr_next_cycle", 1'b0, 1'b0, 32'h0004_0000, 1'b0);
        hook_tap = -1;

        // 0.5 * -2^-16 = -2^-17 must floor to -1 LSB, not round to zero.
        for (int i = 0; i < N_TAPS; i++) write_coef(4'(i), 32'h0);
        write_coef(4'd0, 32'h0000_8000);
        load_vec(1, 32'h0001_0000);
        vec[0] = 32'hFFFF_FFFF;
        run_and_check("trunc_floor", 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0);

        // Reset in the middle of a vector.
        load_vec(1, 32'h0005_0000);
        for (int t = 0; t < 7; t++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = vec[t];
            step();
        end
        bus.in_valid = 1'b0;
        #3 reset = 1'b0;
        #1;
        check("midreset out_valid", 32'(bus.out_valid), 32'd0);
        check("midreset out_data",  bus.out_data,       32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        step();
        check("postreset in_ready",  32'(bus.in_ready),  32'd1);
        check("postreset out_valid", 32'(bus.out_valid), 32'd0);
        load_vec(0, '0);
        run_and_check("postreset_ramp", 1'b0, 1'b0, 32'h0078_0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mac_stream_dot.md
Name: mac_stream_dot

Overview:
Parametrised, streaming fixed-point dot-product engine that replaces hard-wired unrolled MAC chains.
- Accepts one signed sample per cycle over a valid/ready input stream.
- Multiplies each sample by a run-time programmable coefficient and accumulates N_TAPS products per vector.
- Emits one saturated result per vector over a valid/ready output stream.
- Optional accumulate mode carries the running sum across vectors.

Parameters:
DATA_W, 32, sample/coefficient/result width, signed two's complement
FRAC_W, 16, fractional bits (default Q16.16)
N_TAPS, 16, samples per vector, >=2
ADDR_W, $clog2(N_TAPS), coefficient address and tap-counter width
ACC_W, 2*DATA_W-FRAC_W+$clog2(N_TAPS)+1, internal accumulator width (derived, do not override)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
coef_we  in  1  coefficient write strobe
coef_addr  in  ADDR_W  coefficient index
coef_wdata  in  DATA_W  coefficient value (Q format)
accumulate  in  1  sampled with first sample of a vector; 1 = seed accumulator with previous vector's internal sum
in_valid  in  1  sample valid
in_ready  out  1  block can accept a sample
in_data  in  DATA_W  sample
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  DATA_W  saturated result
out_sat  out  1  out_data was clipped

Behaviour:
- Reset (reset=0, asynchronous):
  - State IDLE, tap counter 0, accumulator 0.
  - out_valid=0, out_data=0, out_sat=0.
  - All coefficients = 1<<FRAC_W (1.0).
  - in_ready=1 from the first clock after release.
  - Reset mid-vector discards all partial work.
- Coefficient bank: N_TAPS x DATA_W registers.
  - A write in cycle k is visible to samples accepted from cycle k+1 onward.
  - If a sample accepted in cycle k uses the address being written in cycle k, it sees the old value.
  - Writes are legal in every state.
- Sample accept: in_valid && in_ready. Sample number t of a vector (t = tap counter, 0..N_TAPS-1) uses coef[t].
- Pipeline:
  - S1 registers the full 2*DATA_W signed product.
  - S2 arithmetically shifts the product right by FRAC_W (truncate toward minus infinity), sign-extends to ACC_W and adds it to the accumulator.
  - The first product of a vector adds to 0, or to the previous vector's unsaturated internal sum when accumulate=1 was sampled on that first sample.
  - The internal sum wraps modulo 2^ACC_W; no overflow for a single vector.
- States:
  - IDLE: tap=0, in_ready=1. Accept -> RUN, tap=1.
  - RUN: in_ready=1. Each accept increments tap. Accepting tap N_TAPS-1 -> FLUSH, tap wraps to 0.
  - FLUSH: in_ready=0 for 2 cycles while the pipeline drains, then -> HOLD.
  - HOLD: out_valid=1, in_ready=0. out_data and out_sat are stable until out_ready=1. On the handshake cycle -> IDLE, out_valid=0 next cycle.
- Gaps: in_valid gaps in RUN are allowed; the tap counter and accumulator hold.
- Latency: last sample accepted in cycle c -> out_valid=1 in cycle c+3.
- Throughput: best case one vector every N_TAPS+3 cycles.
- Saturation, from the internal sum:
  - Sum > 2^(DATA_W-1)-1 -> out_data = 0x7FFF_FFFF (DATA_W=32), out_sat=1.
  - Sum < -2^(DATA_W-1) -> out_data = 0x8000_0000, out_sat=1.
  - Otherwise out_data = low DATA_W bits of the sum, out_sat=0.
- Pin behaviour:
  - in_ready is a registered function of state only, with no combinational path from out_ready.
  - in_data and in_valid are ignored whenever in_ready=0.

Test Plan:
1. Reset, default coefficients, samples i<<16 for i=0..15, out_ready=1 -> out_data=0x0078_0000 (120.0), out_sat=0, out_valid exactly 3 cycles after the last accept.
2. Write all coefficients to 0, then coef[3]=0x0002_0000 (2.0); sample 3 = 0xFFFE_8000 (-1.5), others 0x0001_0000 -> out_data=0xFFFD_0000 (-3.0).
3. Default coefficients, all samples 0x7FFF_0000 -> out_data=0x7FFF_FFFF, out_sat=1. All samples 0x8000_0000 -> out_data=0x8000_0000, out_sat=1.
4. out_ready held low 5 cycles in HOLD -> out_valid, out_data and out_sat constant and in_ready=0. Handshake releases the block; in_ready=1 the next cycle. Random in_valid gaps within a vector give the same result as gap-free input.
5. Two vectors of sixteen 0x0001_0000, second with accumulate=1 -> results 0x0010_0000 then 0x0020_0000. Third vector with accumulate=0 -> 0x0010_0000.
6. Assert reset after 7 accepted samples -> out_valid=0, in_ready=1 after release, coefficients back to 1.0. Next full vector matches scenario 1.
